// File: rtl/matrix_row_loader_if.sv
// Handshake bundles for the matrix row loader: the narrow input word stream
// and the registered narrow write port of the matrix RAM.

interface matrix_row_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

interface matrix_row_loader_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_strb;

  modport master (output write, output address, output write_data, output write_strb);
  modport slave  (input write, input address, input write_data, input write_strb);
endinterface

// File: rtl/matrix_row_loader.sv
// Write-side sequencer for the write-narrow/read-wide matrix RAM. Turns a
// programmed (base, count) transfer plus a valid/ready word stream into
// registered narrow RAM writes, flags each completed wide row and pulses
// done when the transfer ends.

module matrix_row_loader #(
  parameter int DATA_RATIO = 8,
  parameter int ADDR_DEPTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_base_addr,
  input  logic [LEN_WIDTH-1:0]          i_num_words,
  output logic                          o_busy,
  output logic                          o_done,
  matrix_row_loader_if.slave            s_if,
  matrix_row_loader_mem_if.master       mem_if,
  output logic                          o_row_done,
  output logic [$clog2(ADDR_DEPTH)-1:0] o_row_index
);

  localparam int TOTAL_WORDS = ADDR_DEPTH * DATA_RATIO;
  localparam int PTR_W       = $clog2(TOTAL_WORDS);
  localparam int LANE_W      = $clog2(DATA_RATIO);
  localparam int ROW_W       = $clog2(ADDR_DEPTH);
  localparam int STRB_W      = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_writeData;
  logic [STRB_W-1:0]     r_writeStrb;
  logic                  r_rowDone;
  logic [ROW_W-1:0]      r_rowIndex;

  logic                  w_handshake;
  logic                  w_lastWord;
  logic                  w_rowEnd;
  logic [LANE_W-1:0]     w_lane;
  logic [ROW_W-1:0]      w_row;
  logic [PTR_W-1:0]      w_ptrNext;

  // Since DATA_RATIO is a power of two the pointer splits cleanly into
  // a row field (upper bits) and a lane field (lower bits).
  assign w_handshake = s_if.valid & r_busy;
  assign w_lastWord  = (r_remaining == LEN_WIDTH'(1));
  assign w_lane      = r_ptr[LANE_W-1:0];
  assign w_row       = r_ptr[PTR_W-1:LANE_W];
  assign w_rowEnd    = (w_lane == {LANE_W{1'b1}});
  assign w_ptrNext   = (r_ptr == PTR_W'(TOTAL_WORDS - 1)) ? '0 : r_ptr + PTR_W'(1);

  // Transfer sequencer: latches the request, issues one registered write
  // per accepted word and generates the row and transfer completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_write     <= 1'b0;
      r_address   <= '0;
      r_writeData <= '0;
      r_writeStrb <= '0;
      r_rowDone   <= 1'b0;
      r_rowIndex  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_write   <= 1'b0;
      r_rowDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_ptr       <= PTR_W'(i_base_addr % ADDR_WIDTH'(TOTAL_WORDS));
            r_remaining <= i_num_words;
            if (i_num_words == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= LOAD;
              r_busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_handshake) begin
            r_write     <= 1'b1;
            r_address   <= ADDR_WIDTH'(r_ptr);
            r_writeData <= s_if.data;
            r_writeStrb <= s_if.strb;
            if (w_rowEnd || w_lastWord) begin
              r_rowDone  <= 1'b1;
              r_rowIndex <= w_row;
            end
            r_ptr       <= w_ptrNext;
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (w_lastWord) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign s_if.ready        = r_busy;
  assign mem_if.write      = r_write;
  assign mem_if.address    = r_address;
  assign mem_if.write_data = r_writeData;
  assign mem_if.write_strb = r_writeStrb;
  assign o_row_done        = r_rowDone;
  assign o_row_index       = r_rowIndex;

endmodule

// File: tb/tb_matrix_row_loader.sv
// Testbench for matrix_row_loader: a transfer-level model predicts every
// cycle's outputs, and directed transfers are pinned with literal address
// and row sequences.

module tb_matrix_row_loader;

  localparam int DATA_RATIO = 8;
  localparam int ADDR_DEPTH = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 16;
  localparam int TOTAL      = ADDR_DEPTH * DATA_RATIO;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [ADDR_WIDTH-1:0] baseAddr = '0;
  logic [LEN_WIDTH-1:0]  numWords = '0;
  logic busy;
  logic done;
  logic rowDone;
  logic [$clog2(ADDR_DEPTH)-1:0] rowIndex;

  int errors = 0;
  int checks = 0;

  matrix_row_loader_if     #(.DATA_WIDTH(DATA_WIDTH)) sIf ();
  matrix_row_loader_mem_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) memIf ();

  matrix_row_loader #(
    .DATA_RATIO(DATA_RATIO),
    .ADDR_DEPTH(ADDR_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_base_addr(baseAddr),
    .i_num_words(numWords),
    .o_busy     (busy),
    .o_done     (done),
    .s_if       (sIf),
    .mem_if     (memIf),
    .o_row_done (rowDone),
    .o_row_index(rowIndex)
  );

  always #5 clk = ~clk;

  initial begin
    sIf.valid = 1'b0;
    sIf.data  = '0;
    sIf.strb  = '0;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfer-level model: a transfer is a base and a count; the k-th accepted
  // word goes to (base + k) mod TOTAL and closes a row on lane 7 or when last.
  bit   modelReady = 0;
  bit   mActive = 0;
  int   mBase, mCount, mIdx;
  logic expBusy, expDone, expWrite, expRowDone, expAllZero;
  logic [31:0] expAddr, expData;
  logic [3:0]  expStrb;
  int   expRow;

  always @(posedge clk) begin
    int a;
    bit last;
    expWrite   = 0;
    expDone    = 0;
    expRowDone = 0;
    expAllZero = 0;
    if (rst) begin
      mActive    = 0;
      expAllZero = 1;
    end else if (!mActive) begin
      if (start) begin
        if (numWords == 0) begin
          expDone = 1;
        end else begin
          mActive = 1;
          mBase   = int'(baseAddr % TOTAL);
          mCount  = int'(numWords);
          mIdx    = 0;
        end
      end
    end else if (sIf.valid) begin
      a          = (mBase + mIdx) % TOTAL;
      last       = (mIdx == mCount - 1);
      expWrite   = 1;
      expAddr    = a;
      expData    = sIf.data;
      expStrb    = sIf.strb;
      expRowDone = ((a % DATA_RATIO) == DATA_RATIO - 1) || last;
      expRow     = a / DATA_RATIO;
      mIdx++;
      if (last) begin
        mActive = 0;
        expDone = 1;
      end
    end
    expBusy    = mActive;
    modelReady = 1;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("busy",     busy,      expBusy);
      checkOutput("s_ready",  sIf.ready, expBusy);
      checkOutput("done",     done,      expDone);
      checkOutput("write",    memIf.write, expWrite);
      checkOutput("row_done", rowDone,   expRowDone);
      if (expWrite) begin
        checkOutput("address", memIf.address,    expAddr);
        checkOutput("data",    memIf.write_data, expData);
        checkOutput("strb",    memIf.write_strb, expStrb);
      end
      if (expRowDone) checkOutput("row_index", rowIndex, expRow);
      if (expAllZero) begin
        checkOutput("rst address",   memIf.address,    0);
        checkOutput("rst data",      memIf.write_data, 0);
        checkOutput("rst strb",      memIf.write_strb, 0);
        checkOutput("rst row_index", rowIndex,         0);
      end
    end
  end

  // Log of writes, row completions and done pulses for the literal checks.
  int wrQ[$];
  int rowQ[$];
  bit doneSeen = 0;

  always @(negedge clk) begin
    if (done) doneSeen = 1;
    if (memIf.write) wrQ.push_back(int'(memIf.address));
    if (rowDone) rowQ.push_back(int'(rowIndex));
  end

  task automatic clearLog();
    wrQ.delete();
    rowQ.delete();
    doneSeen = 0;
  endtask

  // mode 0: continuous valid, 1: valid every other cycle,
  // 2: continuous valid with a competing start pulse mid-transfer.
  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] num, input int mode);
    int cyc;
    @(posedge clk); #1;
    start = 1; baseAddr = base; numWords = num; sIf.valid = 0;
    @(posedge clk); #1;
    start = 0;
    cyc = 0;
    while (!doneSeen && cyc < 200) begin
      sIf.valid = (mode != 1) || (cyc % 2 == 0);
      sIf.data  = $urandom;
      sIf.strb  = 4'($urandom_range(0, 15));
      if (mode == 2) begin
        start    = (cyc == 3);
        baseAddr = (cyc == 3) ? 32'd20 : base;
        numWords = (cyc == 3) ? 16'd2 : num;
      end
      @(negedge clk);
      cyc++;
      if (!doneSeen) begin
        @(posedge clk); #1;
      end
    end
    sIf.valid = 0;
    start = 0;
    if (!doneSeen) checkOutput("transfer timeout", 0, 1);
  endtask

  task automatic checkLog(input string tag, input int addrs[$], input int rows[$]);
    checkOutput({tag, " write count"}, wrQ.size(), addrs.size());
    for (int i = 0; i < addrs.size() && i < wrQ.size(); i++)
      checkOutput($sformatf("%s addr%0d", tag, i), wrQ[i], addrs[i]);
    checkOutput({tag, " row count"}, rowQ.size(), rows.size());
    for (int i = 0; i < rows.size() && i < rowQ.size(); i++)
      checkOutput($sformatf("%s row%0d", tag, i), rowQ[i], rows[i]);
  endtask

  initial begin
    int addrs[$];
    $display("[TB] starting matrix_row_loader bench");
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("reset busy",    busy,        0);
    checkOutput("reset s_ready", sIf.ready,   0);
    checkOutput("reset write",   memIf.write, 0);

    // Two full rows from address 0.
    clearLog();
    applyStimulus(32'd0, 16'd16, 0);
    addrs.delete();
    for (int i = 0; i < 16; i++) addrs.push_back(i);
    checkLog("full", addrs, '{0, 1});

    // Unaligned start, gapped valid, partial final row.
    clearLog();
    applyStimulus(32'd5, 16'd6, 1);
    checkLog("gap", '{5, 6, 7, 8, 9, 10}, '{0, 1});

    // Wrap past the top of the RAM.
    clearLog();
    applyStimulus(32'd30, 16'd4, 0);
    checkLog("wrap", '{30, 31, 0, 1}, '{3, 0});

    // Zero-length transfer.
    clearLog();
    applyStimulus(32'd9, 16'd0, 0);
    checkLog("zero", '{}, '{});
    checkOutput("zero done", doneSeen, 1);

    // Base beyond RAM size folds modulo; competing start is ignored.
    clearLog();
    applyStimulus(32'd168, 16'd10, 2);
    addrs.delete();
    for (int i = 8; i < 18; i++) addrs.push_back(i);
    checkLog("midstart", addrs, '{1, 2});

    // Reset after three accepted words abandons the transfer.
    clearLog();
    @(posedge clk); #1;
    start = 1; baseAddr = 32'd3; numWords = 16'd10;
    @(posedge clk); #1;
    start = 0; sIf.valid = 1;
    repeat (3) begin
      sIf.data = $urandom;
      sIf.strb = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; sIf.valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkLog("reset", '{3, 4, 5}, '{});
    checkOutput("reset no done", doneSeen, 0);

    // Fresh transfer after reset starts from its own base.
    clearLog();
    applyStimulus(32'd12, 16'd2, 0);
    checkLog("after reset", '{12, 13}, '{1});

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_row_loader.md
# matrix_row_loader

Write-side sequencer that sits directly upstream of the asymmetric write-narrow/read-wide matrix RAM. It accepts a valid/ready stream of narrow matrix words and converts a programmed transfer (base word address, word count) into the RAM's registered narrow write interface. It signals when each wide row of DATA_RATIO words is complete so the wide-read consumer can fetch it, and pulses `done` at the end of the transfer.

## Interface
- DATA_RATIO, 8, narrow words per wide RAM row; power of two ≥ 2
- ADDR_DEPTH, 32, number of wide rows in the RAM
- ADDR_WIDTH, 32, width of narrow-word address
- DATA_WIDTH, 32, narrow word width; multiple of 8
- LEN_WIDTH, 16, width of transfer word count

- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin transfer; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first narrow-word address; sampled with start
- num_words  in  LEN_WIDTH  words to transfer; sampled with start
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse at transfer end
- s_valid  in  1  input word valid
- s_ready  out  1  loader accepts word
- s_data  in  DATA_WIDTH  input word
- s_strb  in  DATA_WIDTH/8  byte enables for word
- mem_if_write  out  1  RAM write enable
- mem_if_address  out  ADDR_WIDTH  narrow-word address
- mem_if_write_data  out  DATA_WIDTH  write data
- mem_if_write_strb  out  DATA_WIDTH/8  write byte strobes
- row_done  out  1  one-cycle pulse: wide row written (full or final partial)
- row_index  out  $clog2(ADDR_DEPTH)  wide row index valid with row_done

## Operation
- States: IDLE, LOAD.
- IDLE: s_ready=0, busy=0. On start: latch ptr=base_addr mod (ADDR_DEPTH*DATA_RATIO), remaining=num_words.
  - num_words==0: stay IDLE, pulse done the next cycle; no writes.
  - Otherwise go to LOAD.
- LOAD: s_ready=1, busy=1. Handshake = s_valid & s_ready.
  - Per handshake: register write of s_data/s_strb at ptr. ptr increments by 1 and wraps from ADDR_DEPTH*DATA_RATIO-1 to 0. remaining decrements by 1.
  - Handshake with remaining==1 (final word): go to IDLE.
- Wide row of a word = ptr / DATA_RATIO; lane = ptr mod DATA_RATIO.
- row_done is asserted alongside a write when lane==DATA_RATIO-1 or the word is the final word. row_index = that word's row.
- start while in LOAD: ignored. s_valid in IDLE: ignored (s_ready=0).
- Strobes pass through unmodified; an all-zero strobe still counts as a word and still issues a write.

## Timing
- Reset values: busy=0, done=0, s_ready=0, mem_if_write=0, mem_if_address=0, mem_if_write_data=0, mem_if_write_strb=0, row_done=0, row_index=0; state=IDLE.
- start at cycle t (IDLE) → busy=1, s_ready=1 at t+1.
- Handshake at cycle t → mem_if_write=1 with address/data/strb at t+1. row_done/row_index also at t+1 when applicable.
- Final handshake at t → at t+1: last write, done=1, busy=0, s_ready=0. A new start is accepted at t+1.
- Back-to-back valid sustains 1 word/cycle. A gap in s_valid produces mem_if_write=0 in the corresponding cycle.
- Zero-length start at t → done=1 at t+1, busy stays 0.
- rst in any state: outputs take reset values next cycle. An in-flight transfer is abandoned; no done pulse and no further writes.
- mem_if_write is high for exactly one cycle per accepted word; never without a preceding handshake.

## Test plan
- DATA_RATIO=8, base=0, num=16, continuous valid → 16 writes at addr 0..15 on consecutive cycles; row_done at addr 7 (row 0) and addr 15 (row 1); done coincides with the addr-15 write.
- base=5, num=6, valid toggling 1/0 → writes at 5..10 only on handshake+1 cycles; row_done at addr 7 (row 0) and addr 10 (row 1, partial); done with the addr-10 write.
- Wrap: ADDR_DEPTH=4, base=30, num=4 → addresses 30, 31, 0, 1; row_done rows 3 and 0; done at the final write.
- num_words=0 → done pulse one cycle after start; mem_if_write never asserted; busy never asserted.
- start pulsed mid-LOAD with a different base/num → ignored; original transfer completes unchanged.
- rst asserted after 3 of 10 words → all outputs return to reset values next cycle; no done pulse. A fresh start afterwards restarts from its own base.
